// File: rtl/div32_pkg.sv
// ============================================================================
// Module   : div32_pkg
// Brief    : Shared constants and sideband layout for the div32 issue stage.
//            Sign bits exist only when DIV32_SIGNED_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package div32_pkg;

    localparam int          DIV_LAT_DEF = 2;
    localparam logic [31:0] DZ_QUOT     = 32'hFFFF_FFFF;

    // Per-request information that travels alongside the divider pipeline.
    // The issuing module wraps this with vld and its own-width tag.
    typedef struct packed {
        logic        dz;
        logic        ovf;
        logic [31:0] x_lo;
`ifdef DIV32_SIGNED_EN
        logic        sx;
        logic        sd;
`endif
    } sb_info_t;

endpackage

`default_nettype wire

// File: rtl/div32_issue_if.sv
// ============================================================================
// Module   : div32_issue_if
// Brief    : Request, divider and response signal bundle for div32_issue.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface div32_issue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_x;
    logic [31:0]      in_d;
    logic [TAG_W-1:0] in_tag;

    logic [63:0]      div_x;
    logic [31:0]      div_d;
    logic [31:0]      div_q;
    logic [31:0]      div_r;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_q;
    logic [31:0]      out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_dz;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_x, in_d, in_tag, div_q, div_r, out_ready,
        output in_ready, div_x, div_d, out_valid, out_q, out_r, out_tag, out_dz, out_ovf
    );

    modport master (
        output in_valid, in_x, in_d, in_tag, div_q, div_r, out_ready,
        input  in_ready, div_x, div_d, out_valid, out_q, out_r, out_tag, out_dz, out_ovf
    );

endinterface

`default_nettype wire

// File: rtl/div32_rsp_fifo.sv
// ============================================================================
// Module   : div32_rsp_fifo
// Brief    : Synchronous FIFO with wrap-around pointers, count, empty, full.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div32_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rstn) begin
            assert (!(push_i && full_o));
        end
    end

endmodule

`default_nettype wire

// File: rtl/div32_issue.sv
// ============================================================================
// Module   : div32_issue
// Brief    : Valid/ready issue stage, sideband pipe, credits and response FIFO
//            around a fixed-latency 64/32 divider. Signed: DIV32_SIGNED_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div32_issue
    import div32_pkg::*;
#(
    parameter int DIV_LAT    = DIV_LAT_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic          clk,
    input  logic          rstn,
    div32_issue_if.slave  div_if
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = TAG_W + 2 + 64;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        sb_info_t         info;
    } sb_t;

    logic             ready_en_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    sb_t              sb_q [DIV_LAT];
    sb_t              w_sb_in;
    sb_t              w_tail;
    logic             w_accept;
    logic             w_pop;
    logic             w_dz;
    logic             w_ovf;
    logic [31:0]      w_rsp_q;
    logic [31:0]      w_rsp_r;
    logic [ENT_W-1:0] w_rdata;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic             w_empty;
    logic             w_full;

    assign div_if.in_ready = ready_en_q && (cnt_q < CNT_W'(FIFO_DEPTH));
    assign w_accept        = div_if.in_valid && div_if.in_ready;
    assign w_pop           = div_if.out_valid && div_if.out_ready;
    assign w_dz            = (div_if.in_d == '0);

`ifdef DIV32_SIGNED_EN
    logic [63:0] w_abs_x;
    logic [31:0] w_abs_d;

    assign w_abs_x      = div_if.in_x[63] ? (64'd0 - div_if.in_x) : div_if.in_x;
    assign w_abs_d      = div_if.in_d[31] ? (32'd0 - div_if.in_d) : div_if.in_d;
    assign div_if.div_x = w_abs_x;
    assign div_if.div_d = w_abs_d;
    // Magnitude quotient must stay below 2^31; this also rejects -2^31.
    assign w_ovf        = !w_dz && (w_abs_x[63:31] >= {1'b0, w_abs_d});
`else
    assign div_if.div_x = div_if.in_x;
    assign div_if.div_d = div_if.in_d;
    assign w_ovf        = !w_dz && (div_if.in_x[63:32] >= div_if.in_d);
`endif

    always_comb begin
        w_sb_in           = '0;
        w_sb_in.vld       = w_accept;
        w_sb_in.tag       = div_if.in_tag;
        w_sb_in.info.dz   = w_dz;
        w_sb_in.info.ovf  = w_ovf;
        w_sb_in.info.x_lo = div_if.in_x[31:0];
`ifdef DIV32_SIGNED_EN
        w_sb_in.info.sx   = div_if.in_x[63];
        w_sb_in.info.sd   = div_if.in_d[31];
`endif
    end

    // Sideband stays aligned with the divider: tail matches div_q/div_r.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DIV_LAT; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            sb_q[0] <= w_sb_in;
            for (int i = 1; i < DIV_LAT; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign w_tail = sb_q[DIV_LAT-1];

    always_comb begin
        w_rsp_q = div_if.div_q;
        w_rsp_r = div_if.div_r;
        if (w_tail.info.dz) begin
            w_rsp_q = DZ_QUOT;
            w_rsp_r = w_tail.info.x_lo;
        end
`ifdef DIV32_SIGNED_EN
        else if (!w_tail.info.ovf) begin
            if (w_tail.info.sx ^ w_tail.info.sd) begin
                w_rsp_q = 32'd0 - div_if.div_q;
            end
            if (w_tail.info.sx) begin
                w_rsp_r = 32'd0 - div_if.div_r;
            end
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_accept && !w_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!w_accept && w_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ready_en_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ready_en_q <= 1'b1;
            cnt_q      <= cnt_d;
        end
    end

    div32_rsp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (w_tail.vld),
        .wdata_i ({w_tail.tag, w_tail.info.dz, w_tail.info.ovf, w_rsp_q, w_rsp_r}),
        .pop_i   (w_pop),
        .rdata_o (w_rdata),
        .count_o (w_fifo_cnt),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    assign div_if.out_valid = !w_empty;
    assign {div_if.out_tag, div_if.out_dz, div_if.out_ovf,
            div_if.out_q, div_if.out_r} = w_rdata;

    always @(posedge clk) begin
        if (rstn) begin
            assert (w_fifo_cnt <= cnt_q);
            assert (!(w_tail.vld && w_full));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div32_issue.sv
// ============================================================================
// Module   : tb_div32_issue
// Brief    : Scoreboard bench for div32_issue with a 2-cycle divider model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div32_issue;

    logic clk;
    logic rstn;

    div32_issue_if #(.TAG_W(4)) bus ();

    div32_issue #(
        .DIV_LAT    (2),
        .FIFO_DEPTH (4),
        .TAG_W      (4)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .div_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Exact two-stage divider model fed from div_x/div_d.
    logic [31:0] s1_q, s1_r, s2_q, s2_r;
    always @(posedge clk) begin
        if (bus.div_d == 32'd0) begin
            s1_q <= 32'd0;
            s1_r <= 32'd0;
        end else begin
            s1_q <= 32'(bus.div_x / {32'd0, bus.div_d});
            s1_r <= 32'(bus.div_x % {32'd0, bus.div_d});
        end
        s2_q <= s1_q;
        s2_r <= s1_r;
    end
    assign bus.div_q = s2_q;
    assign bus.div_r = s2_r;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  tag;
        logic        dz;
        logic        ovf;
        bit          lat;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_acc  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                chk("stale_rsp", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_q",   64'(bus.out_q),   64'(mon_e.q));
                chk("rsp_r",   64'(bus.out_r),   64'(mon_e.r));
                chk("rsp_tag", 64'(bus.out_tag), 64'(mon_e.tag));
                chk("rsp_dz",  64'(bus.out_dz),  64'(mon_e.dz));
                chk("rsp_ovf", 64'(bus.out_ovf), 64'(mon_e.ovf));
                if (mon_e.lat) chk("rsp_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [63:0] x, input logic [31:0] d, input logic [3:0] tag,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eovf, input bit lat, output int waited);
        exp_t n;
        bit   ok;
        waited = 0;
        ok     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_d     = d;
        bus.in_tag   = tag;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            chk("accept_timeout", 64'd1, 64'd0);
        end else begin
            n.q = eq; n.r = er; n.tag = tag; n.dz = edz; n.ovf = eovf;
            n.lat = lat; n.cyc = cyc + 3;
            sbq.push_back(n);
            n_acc++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_auto(input logic [63:0] x, input logic [31:0] d, input logic [3:0] tag,
                             input bit lat, output int waited);
        send(x, d, tag, 32'(x / {32'd0, d}), 32'(x % {32'd0, d}), 1'b0, 1'b0, lat, waited);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sbq.size() != 0 && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int  w;
    int  base;
    bit  t5_done;

    initial begin
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_d      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        t5_done       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  {bus.out_q, bus.out_r},  64'd0);
        chk("rst_out_side",  64'({bus.out_tag, bus.out_dz, bus.out_ovf}), 64'd0);
        @(posedge clk);
        #1;
        rstn          = 1'b1;
        bus.out_ready = 1'b1;

        // 1: basic divide, 3-cycle latency
        send(64'd100, 32'd7, 4'h5, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1, w);
        drain(20);
        // 2: divide by zero
        send(64'h1234, 32'd0, 4'h6, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1'b1, w);
        drain(20);
        // 3: overflow then a clean request
        send(64'h1_0000_0000, 32'd1, 4'h7, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, w);
        send(64'd5, 32'd2, 4'h8, 32'd2, 32'd1, 1'b0, 1'b0, 1'b1, w);
        drain(20);

        // 4: 20 back-to-back with out_ready high
        for (int i = 0; i < 20; i++) begin
            send_auto(64'($urandom_range(0, 1000000)), 32'($urandom_range(1, 1000)),
                      4'(i), 1'b1, w);
            chk("t4_no_stall", 64'(w), 64'd0);
        end
        drain(20);

        // 5: backpressure fills credits, then release
        base          = n_acc;
        bus.out_ready = 1'b0;
        fork
            begin
                int ww;
                for (int i = 0; i < 6; i++)
                    send_auto(64'(100 + i * 37), 32'(3 + i), 4'(i + 8), 1'b0, ww);
                t5_done = 1'b1;
            end
        join_none
        idle(10);
        @(negedge clk);
        chk("t5_accepts",  64'(n_acc - base), 64'd4);
        chk("t5_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100 && !t5_done; k++) idle(1);
        chk("t5_done",  64'(t5_done), 64'd1);
        drain(30);
        chk("t5_total", 64'(n_acc - base), 64'd6);

        // 6: reset with 2 queued and 2 in flight
        bus.out_ready = 1'b0;
        send_auto(64'd50, 32'd5, 4'h1, 1'b0, w);
        send_auto(64'd60, 32'd7, 4'h2, 1'b0, w);
        idle(4);
        send_auto(64'd70, 32'd3, 4'h3, 1'b0, w);
        send_auto(64'd80, 32'd9, 4'h4, 1'b0, w);
        rstn = 1'b0;
        sbq.delete();
        idle(1);
        @(negedge clk);
        chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_in_ready",  64'(bus.in_ready),  64'd0);
        @(posedge clk);
        #1;
        rstn          = 1'b1;
        bus.out_ready = 1'b1;
        idle(8);
        chk("t6_no_stale", 64'(bus.out_valid), 64'd0);
        send(64'd1000, 32'd9, 4'hA, 32'd111, 32'd1, 1'b0, 1'b0, 1'b1, w);
        drain(20);

`ifdef DIV32_SIGNED_EN
        // 7: signed truncation toward zero
        send(64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 4'hB, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
             1'b0, 1'b0, 1'b1, w);
        send(64'd7, 32'hFFFF_FFFE, 4'hC, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 1'b1, w);
        drain(20);
`endif

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
